dfr_run_sequencer: RTL and testbench
====================================

Name: dfr_run_sequencer

Overview:
- Sequences one complete DFR inference pass, replacing the hard-wired free-running sample counter in the core top.
- On `start` it streams input samples from input memory into the reservoir, one virtual node at a time, and writes every reservoir output to reservoir history memory.
- It then starts the matrix-multiply engine, waits for it to finish, and reports `done`.
- Sits between the AXI config registers (ctrl start/busy bits) and the reservoir, input RAM, history RAM and matrix-multiply blocks.

Parameters:
- ADDR_WIDTH, 14, address width of the input and history RAMs.
- DATA_WIDTH, 32, reservoir and RAM data width.
- VIRTUAL_NODES, 10, reservoir steps per input sample.
- NUM_SAMPLES, 100, input samples per run. NUM_SAMPLES*VIRTUAL_NODES must be ≤ 2**ADDR_WIDTH; elaboration-time assertion.

Ports:
- S_AXI_ACLK  in  1  clock
- S_AXI_ARESETN  in  1  synchronous active-low reset
- start  in  1  run request; sampled only in IDLE
- abort  in  1  cancel current run
- busy  out  1  high in every state except IDLE
- done  out  1  sticky completion flag; cleared by start or reset
- input_mem_addr  out  ADDR_WIDTH  input RAM read address (sample index)
- input_mem_dout  in  DATA_WIDTH  input RAM read data; 1-cycle read latency
- reservoir_en  out  1  reservoir step strobe
- reservoir_din  out  DATA_WIDTH  reservoir input
- reservoir_dout  in  DATA_WIDTH  reservoir output; valid 1 cycle after reservoir_en
- hist_addr  out  ADDR_WIDTH  history write address = sample*VIRTUAL_NODES + node
- hist_wen  out  1  history write enable
- hist_din  out  DATA_WIDTH  history write data
- mm_start  out  1  matrix-multiply start pulse
- mm_busy  in  1  matrix-multiply busy
- run_cycles  out  32  performance counter (see Optional Feature)

Behaviour:
- Reset (S_AXI_ARESETN=0 at a clock edge) forces the following; `done` is also cleared.
  - state=IDLE
  - all outputs 0
  - sample and node counters 0
- State machine: IDLE, FETCH, STEP, STORE, MM_START, MM_WAIT, FINISH.
- IDLE:
  - start=1: clear done and counters, go to FETCH.
  - start=0: stay.
- FETCH: drive input_mem_addr=sample; go to STEP.
- STEP (input data valid this cycle):
  - reservoir_en=1, reservoir_din=input_mem_dout.
  - Go to STORE.
- STORE:
  - hist_wen=1, hist_din=reservoir_dout, hist_addr=sample*VIRTUAL_NODES+node.
  - Then advance the counters:
    - node<VIRTUAL_NODES-1: node++.
    - else node=0, sample++.
  - Next state:
    - Last node of last sample: MM_START.
    - Otherwise FETCH.
- Each reservoir step takes exactly 3 cycles. The input phase takes 3*NUM_SAMPLES*VIRTUAL_NODES cycles.
- MM_START: mm_start=1 for exactly one cycle; go to MM_WAIT.
- MM_WAIT:
  - A seen_busy flag is set when mm_busy=1 is observed.
  - Exit to FINISH when seen_busy=1 and mm_busy=0. mm_busy asserted in the same cycle as mm_start counts as seen.
- FINISH: set done=1; go to IDLE.
- busy deasserts on the cycle the FSM enters IDLE.
- start while busy: ignored; no queueing.
- abort=1 in any non-IDLE state:
  - Next state IDLE; done stays 0.
  - All strobes (reservoir_en, hist_wen, mm_start) are 0 from that cycle onward.
  - Counters reset.
- abort has priority over every state transition.
- start and abort asserted together in IDLE: abort wins; stay in IDLE.
- Reset mid-run: identical to power-on reset; an in-flight matrix multiply is not cancelled by this block.
- Address arithmetic: compute hist_addr as an incrementing counter that runs in lock-step with node/sample, not with a multiplier. The counter is ADDR_WIDTH bits wide and never wraps because of the parameter assertion.
- All outputs are registered, except strobes decoded directly from the state register.

Optional Feature:
- Macro DFR_SEQ_PERF_CNT_EN.
- Defined:
  - run_cycles counts every clock with busy=1.
  - Cleared when start is accepted.
  - Holds its value after the run completes or aborts.
  - Saturates at 32'hFFFF_FFFF.
- Undefined: run_cycles is tied to 0 and no counter logic is generated.

Decomposition:
- Package dfr_pkg holds:
  - typedef enum logic [2:0] dfr_seq_state_t (the seven states);
  - constant DFR_SEQ_STEP_CYCLES=3.
- Sub-module dfr_step_counter: nested node/sample counter with linear history address, last-step flag and synchronous clear. Parameters are VIRTUAL_NODES, NUM_SAMPLES and ADDR_WIDTH.

Test Plan (parameters VIRTUAL_NODES=2, NUM_SAMPLES=3 unless noted):
- Reset:
  - Stimulus: hold S_AXI_ARESETN=0 for 3 clocks while start=1.
  - Response: busy=done=reservoir_en=hist_wen=mm_start=0; stays IDLE after release until start.
- Full run:
  - Stimulus: input RAM = {10,20,30}; reservoir model returns din+1; mm model holds busy for 5 cycles.
  - Response: exactly 6 hist writes at addr 0..5 with data {11,11,21,21,31,31}; mm_start pulses once, 18 cycles after start.
  - Response: done=1 one cycle after mm_busy falls. With DFR_SEQ_PERF_CNT_EN, run_cycles=26 (18 + MM_START + 5 MM_WAIT busy + final MM_WAIT + FINISH).
- Abort mid-run:
  - Stimulus: abort pulsed on the 2nd STORE.
  - Response: hist_wen seen only for addr 0; busy=0 next cycle; done=0; mm_start never asserted.
- Start while busy:
  - Stimulus: pulse start 5 cycles into a run.
  - Response: run unaffected (6 writes, single done); no second run begins.
- Slow matrix multiply:
  - Stimulus: mm_busy rises 4 cycles after mm_start.
  - Response: the FSM stays in MM_WAIT and done is not asserted before mm_busy rises then falls.
- Max size (ADDR_WIDTH=4, VIRTUAL_NODES=4, NUM_SAMPLES=4):
  - Response: hist_addr reaches 15 with no wrap; 16 writes total.

Source files
------------

// File: rtl/dfr_pkg.sv
// dfr_pkg: shared types and constants for the DFR run sequencer.
// Holds the sequencer state encoding and the fixed cost of one
// reservoir step (FETCH -> STEP -> STORE).
package dfr_pkg;

  // Cycles spent per virtual-node step: fetch, reservoir step, history store.
  localparam int DFR_SEQ_STEP_CYCLES = 3;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    STEP     = 3'd2,
    STORE    = 3'd3,
    MM_START = 3'd4,
    MM_WAIT  = 3'd5,
    FINISH   = 3'd6
  } dfr_seq_state_t;

endpackage

// File: rtl/dfr_run_sequencer_if.sv
// dfr_run_sequencer_if: datapath bundle between the run sequencer and the
// input RAM, reservoir, history RAM and matrix-multiply engine.
// The master side is the sequencer; the slave side is the surrounding core.
interface dfr_run_sequencer_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
);

  // Input RAM read port (1-cycle read latency)
  logic [ADDR_WIDTH-1:0] input_mem_addr;
  logic [DATA_WIDTH-1:0] input_mem_dout;

  // Reservoir step port (output valid 1 cycle after reservoir_en)
  logic                  reservoir_en;
  logic [DATA_WIDTH-1:0] reservoir_din;
  logic [DATA_WIDTH-1:0] reservoir_dout;

  // History RAM write port
  logic [ADDR_WIDTH-1:0] hist_addr;
  logic                  hist_wen;
  logic [DATA_WIDTH-1:0] hist_din;

  // Matrix-multiply control
  logic                  mm_start;
  logic                  mm_busy;

  modport master (
    output input_mem_addr,
    input  input_mem_dout,
    output reservoir_en,
    output reservoir_din,
    input  reservoir_dout,
    output hist_addr,
    output hist_wen,
    output hist_din,
    output mm_start,
    input  mm_busy
  );

  modport slave (
    input  input_mem_addr,
    output input_mem_dout,
    input  reservoir_en,
    input  reservoir_din,
    output reservoir_dout,
    input  hist_addr,
    input  hist_wen,
    input  hist_din,
    input  mm_start,
    output mm_busy
  );

endinterface

// File: rtl/dfr_step_counter.sv
// dfr_step_counter: nested node/sample counter for the run sequencer.
// The history address is kept as its own incrementing counter that moves in
// lock-step with node/sample, so no multiplier is needed. After the last step
// of the run every counter returns to zero, which keeps the address counter
// from ever wrapping.
module dfr_step_counter #(
  parameter int VIRTUAL_NODES = 10,
  parameter int NUM_SAMPLES   = 100,
  parameter int ADDR_WIDTH    = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  advance,
  output logic [ADDR_WIDTH-1:0] sample,
  output logic [ADDR_WIDTH-1:0] hist_addr,
  output logic                  last
);

  localparam int NODE_W = (VIRTUAL_NODES > 1) ? $clog2(VIRTUAL_NODES) : 1;

  // Every history address must fit in the RAM address space.
  if ((longint'(NUM_SAMPLES) * longint'(VIRTUAL_NODES)) > (longint'(1) << ADDR_WIDTH)) begin : g_size_check
    $error("dfr_step_counter: NUM_SAMPLES*VIRTUAL_NODES exceeds 2**ADDR_WIDTH");
  end

  if (VIRTUAL_NODES < 1 || NUM_SAMPLES < 1) begin : g_min_check
    $error("dfr_step_counter: VIRTUAL_NODES and NUM_SAMPLES must be at least 1");
  end

  logic [NODE_W-1:0]     node_reg;
  logic [ADDR_WIDTH-1:0] sample_reg;
  logic [ADDR_WIDTH-1:0] hist_addr_reg;
  logic                  node_last;
  logic                  sample_last;

  assign node_last   = (node_reg == NODE_W'(VIRTUAL_NODES - 1));
  assign sample_last = (sample_reg == ADDR_WIDTH'(NUM_SAMPLES - 1));
  assign last        = node_last && sample_last;

  // Advance node within a sample, roll over into the next sample, reset after the final step.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      node_reg      <= '0;
      sample_reg    <= '0;
      hist_addr_reg <= '0;
    end else if (advance) begin
      if (last) begin
        node_reg      <= '0;
        sample_reg    <= '0;
        hist_addr_reg <= '0;
      end else begin
        hist_addr_reg <= hist_addr_reg + 1'b1;
        if (node_last) begin
          node_reg   <= '0;
          sample_reg <= sample_reg + 1'b1;
        end else begin
          node_reg <= node_reg + 1'b1;
        end
      end
    end
  end

  assign sample    = sample_reg;
  assign hist_addr = hist_addr_reg;

endmodule

// File: rtl/dfr_run_sequencer.sv
// dfr_run_sequencer: sequences one DFR inference pass.
// On start it streams every input sample through the reservoir once per
// virtual node (FETCH/STEP/STORE), logs every reservoir output to history
// RAM, then kicks the matrix-multiply engine and waits for it to finish.
// Optional build macro: DFR_SEQ_PERF_CNT_EN enables the run_cycles counter
// (busy cycles of the latest run, saturating); otherwise run_cycles is 0.
module dfr_run_sequencer
  import dfr_pkg::*;
#(
  parameter int ADDR_WIDTH    = 14,
  parameter int DATA_WIDTH    = 32,
  parameter int VIRTUAL_NODES = 10,
  parameter int NUM_SAMPLES   = 100
) (
  input  logic                S_AXI_ACLK,
  input  logic                S_AXI_ARESETN,
  input  logic                start,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic [31:0]         run_cycles,
  dfr_run_sequencer_if.master bus
);

  localparam int INPUT_PHASE_CYCLES = DFR_SEQ_STEP_CYCLES * NUM_SAMPLES * VIRTUAL_NODES;

  // A run with no steps would jump straight to the matrix multiply with stale history.
  if (INPUT_PHASE_CYCLES < DFR_SEQ_STEP_CYCLES) begin : g_phase_check
    $error("dfr_run_sequencer: a run needs at least one reservoir step");
  end

  dfr_seq_state_t state_reg;
  dfr_seq_state_t state_next;

  logic                  start_accept;
  logic                  abort_run;
  logic                  busy_w;
  logic                  reservoir_en_w;
  logic                  hist_wen_w;
  logic                  mm_start_w;
  logic                  seen_busy_reg;
  logic                  done_reg;
  logic                  step_last;
  logic [ADDR_WIDTH-1:0] sample_w;
  logic [ADDR_WIDTH-1:0] hist_addr_w;

  // A start request only counts from IDLE, and abort beats it even there.
  assign start_accept = (state_reg == IDLE) && start && !abort;
  assign abort_run    = (state_reg != IDLE) && abort;

  // Node/sample bookkeeping; steps advance on each committed history write.
  dfr_step_counter #(
    .VIRTUAL_NODES (VIRTUAL_NODES),
    .NUM_SAMPLES   (NUM_SAMPLES),
    .ADDR_WIDTH    (ADDR_WIDTH)
  ) u_step_counter (
    .clk       (S_AXI_ACLK),
    .rst_n     (S_AXI_ARESETN),
    .clear     (start_accept || abort_run),
    .advance   (hist_wen_w),
    .sample    (sample_w),
    .hist_addr (hist_addr_w),
    .last      (step_last)
  );

  // State register.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and strobe decode; abort overrides every transition and kills the strobes at once.
  always_comb begin
    state_next     = state_reg;
    busy_w         = (state_reg != IDLE);
    reservoir_en_w = 1'b0;
    hist_wen_w     = 1'b0;
    mm_start_w     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        state_next = STEP;
      end
      STEP: begin
        reservoir_en_w = 1'b1;
        state_next     = STORE;
      end
      STORE: begin
        hist_wen_w = 1'b1;
        state_next = step_last ? MM_START : FETCH;
      end
      MM_START: begin
        mm_start_w = 1'b1;
        state_next = MM_WAIT;
      end
      MM_WAIT: begin
        if (seen_busy_reg && !bus.mm_busy) begin
          state_next = FINISH;
        end
      end
      FINISH: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (abort) begin
      state_next     = IDLE;
      reservoir_en_w = 1'b0;
      hist_wen_w     = 1'b0;
      mm_start_w     = 1'b0;
    end
  end

  // Remember that the engine has actually gone busy, so a slow-to-start engine is not taken as finished.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      seen_busy_reg <= 1'b0;
    end else if (state_reg == IDLE || abort_run) begin
      seen_busy_reg <= 1'b0;
    end else if ((state_reg == MM_START || state_reg == MM_WAIT) && bus.mm_busy) begin
      seen_busy_reg <= 1'b1;
    end
  end

  // Sticky completion flag, raised on entry to FINISH and cleared by a new run or an abort.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      done_reg <= 1'b0;
    end else if (start_accept || abort_run) begin
      done_reg <= 1'b0;
    end else if (state_reg == MM_WAIT && state_next == FINISH) begin
      done_reg <= 1'b1;
    end
  end

`ifdef DFR_SEQ_PERF_CNT_EN
  logic [31:0] run_cycles_reg;

  // Count busy cycles of the current run; hold afterwards, saturate at all-ones.
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      run_cycles_reg <= '0;
    end else if (start_accept) begin
      run_cycles_reg <= '0;
    end else if (busy_w && (run_cycles_reg != 32'hFFFF_FFFF)) begin
      run_cycles_reg <= run_cycles_reg + 32'd1;
    end
  end

  assign run_cycles = run_cycles_reg;
`else
  assign run_cycles = 32'd0;
`endif

  // The input address is the sample counter itself, valid throughout FETCH.
  assign bus.input_mem_addr = sample_w;
  assign bus.hist_addr      = hist_addr_w;

  // Data passes straight through, gated by its strobe so idle buses read as zero.
  assign bus.reservoir_en   = reservoir_en_w;
  assign bus.reservoir_din  = reservoir_en_w ? bus.input_mem_dout : {DATA_WIDTH{1'b0}};
  assign bus.hist_wen       = hist_wen_w;
  assign bus.hist_din       = hist_wen_w ? bus.reservoir_dout : {DATA_WIDTH{1'b0}};
  assign bus.mm_start       = mm_start_w;

  assign busy = busy_w;
  assign done = done_reg;

endmodule

// File: tb/tb_dfr_run_sequencer.sv
// tb_dfr_run_sequencer: self-checking bench for the DFR run sequencer.
// DUT 1 uses VIRTUAL_NODES=2, NUM_SAMPLES=3; DUT 2 is the full-address-space
// case with ADDR_WIDTH=4, VIRTUAL_NODES=4, NUM_SAMPLES=4.
module tb_dfr_run_sequencer;

  localparam int AW  = 14;
  localparam int DW  = 32;
  localparam int VN  = 2;
  localparam int NS  = 3;
  localparam int AW2 = 4;
  localparam int VN2 = 4;
  localparam int NS2 = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort, busy, done;
  logic [31:0] run_cycles;
  logic        start2, abort2, busy2, done2;
  logic [31:0] run_cycles2;

  always #5 clk = ~clk;

  dfr_run_sequencer_if #(.ADDR_WIDTH(AW),  .DATA_WIDTH(DW)) bus  ();
  dfr_run_sequencer_if #(.ADDR_WIDTH(AW2), .DATA_WIDTH(DW)) bus2 ();

  dfr_run_sequencer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .VIRTUAL_NODES(VN), .NUM_SAMPLES(NS)
  ) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .start(start), .abort(abort),
    .busy(busy), .done(done), .run_cycles(run_cycles), .bus(bus.master)
  );

  dfr_run_sequencer #(
    .ADDR_WIDTH(AW2), .DATA_WIDTH(DW), .VIRTUAL_NODES(VN2), .NUM_SAMPLES(NS2)
  ) dut2 (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .start(start2), .abort(abort2),
    .busy(busy2), .done(done2), .run_cycles(run_cycles2), .bus(bus2.master)
  );

  // ---------------- environment models ----------------
  logic [DW-1:0] ram  [4];
  logic [DW-1:0] ram2 [16];
  int mm_len = 5, mm_delay = 1, mm_pre = 0, mm_rem = 0;
  int mm2_rem = 0;

  always @(posedge clk) bus.input_mem_dout  <= ram[bus.input_mem_addr[1:0]];
  always @(posedge clk) bus2.input_mem_dout <= ram2[bus2.input_mem_addr[3:0]];
  always @(posedge clk) if (bus.reservoir_en)  bus.reservoir_dout  <= bus.reservoir_din + 32'd1;
  always @(posedge clk) if (bus2.reservoir_en) bus2.reservoir_dout <= bus2.reservoir_din + 32'd1;

  // Engine goes busy mm_delay cycles after the start pulse, for mm_len cycles.
  always @(posedge clk) begin
    if (bus.mm_start) begin
      mm_pre <= mm_delay - 1;
      mm_rem <= mm_len;
    end else if (mm_pre > 0) begin
      mm_pre <= mm_pre - 1;
    end else if (mm_rem > 0) begin
      mm_rem <= mm_rem - 1;
    end
  end
  assign bus.mm_busy = (mm_pre == 0) && (mm_rem > 0);

  always @(posedge clk) begin
    if (bus2.mm_start) mm2_rem <= 2;
    else if (mm2_rem > 0) mm2_rem <= mm2_rem - 1;
  end
  assign bus2.mm_busy = (mm2_rem > 0);

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] d0, d1, d2;
    int          len;
    int          dly;
    int          restart_at;   // cycle of a stray start pulse while busy, 0 = none
    int          exp_pre_mm;   // busy cycles before mm_start
    int          exp_busy;     // total busy cycles of the run
  } vec_t;

  vec_t vecs [4];

  // One complete run checked against the reference: writes, mm pulse, done timing, cycle count.
  task automatic run_one(input string tag, input logic [31:0] d0, d1, d2, input int len, dly,
                         input int restart_at, exp_pre_mm, exp_busy);
    int wa[$], wd[$];
    int busy_cnt, mm_cnt, pre_mm, last_mmbusy, done_cyc, ended;
    logic [31:0] exp_d;
    ram[0] = d0; ram[1] = d1; ram[2] = d2;
    mm_len = len; mm_delay = dly;
    busy_cnt = 0; mm_cnt = 0; pre_mm = -1; last_mmbusy = -100; done_cyc = -1; ended = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      start = (cyc == restart_at);
      #1;
      if (cyc == 1) check({tag, "_done_cleared"}, int'(done), 0);
      if (!busy) begin
        ended = 1;
        break;
      end
      busy_cnt++;
      if (bus.hist_wen) begin
        wa.push_back(int'(bus.hist_addr));
        wd.push_back(int'(bus.hist_din));
      end
      if (bus.mm_start) begin
        mm_cnt++;
        pre_mm = busy_cnt - 1;
      end
      if (bus.mm_busy) last_mmbusy = cyc;
      if (done && done_cyc < 0) done_cyc = cyc;
      @(negedge clk);
    end
    start = 1'b0;
    check({tag, "_ended"}, ended, 1);
    check({tag, "_nwrites"}, wa.size(), NS * VN);
    for (int s = 0; s < NS; s++) begin
      for (int n = 0; n < VN; n++) begin
        int i = s * VN + n;
        exp_d = ram[s] + 32'd1;
        if (i < wa.size()) begin
          check($sformatf("%s_addr%0d", tag, i), wa[i], i);
          check($sformatf("%s_data%0d", tag, i), wd[i], int'(exp_d));
        end
      end
    end
    check({tag, "_mm_pulses"}, mm_cnt, 1);
    check({tag, "_mm_offset"}, pre_mm, exp_pre_mm);
    check({tag, "_done_timing"}, done_cyc, last_mmbusy + 2);
    check({tag, "_busy_cycles"}, busy_cnt, exp_busy);
    check({tag, "_done_sticky"}, int'(done), 1);
`ifdef DFR_SEQ_PERF_CNT_EN
    check({tag, "_run_cycles"}, int'(run_cycles), exp_busy);
`else
    check({tag, "_run_cycles"}, int'(run_cycles), 0);
`endif
    repeat (3) @(negedge clk);
    #1 check({tag, "_no_second_run"}, int'(busy), 0);
    $display("run %s: %0d writes, mm_start after %0d busy cycles, %0d busy cycles total",
             tag, wa.size(), pre_mm, busy_cnt);
  endtask

  initial begin
    int wcnt, max_addr, ended, mm_cnt;
    logic [31:0] exp_d;
    start = 0; abort = 0; start2 = 0; abort2 = 0; rst_n = 0;
    for (int i = 0; i < 4; i++) ram[i] = '0;
    for (int i = 0; i < 16; i++) ram2[i] = 32'(100 * i + 5);

    vecs[0] = '{d0: 10, d1: 20, d2: 30,           len: 5, dly: 1, restart_at: 0, exp_pre_mm: 18, exp_busy: 26};
    vecs[1] = '{d0: 10, d1: 20, d2: 30,           len: 5, dly: 1, restart_at: 5, exp_pre_mm: 18, exp_busy: 26};
    vecs[2] = '{d0: 7,  d1: 0,  d2: 32'hFFFFFFFF, len: 1, dly: 1, restart_at: 0, exp_pre_mm: 18, exp_busy: 22};
    vecs[3] = '{d0: 1,  d1: 2,  d2: 3,            len: 3, dly: 4, restart_at: 9, exp_pre_mm: 18, exp_busy: 27};

    // Reset held for 3 clocks with start asserted.
    start = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      check($sformatf("reset_strobes%0d", k),
            int'({busy, done, bus.reservoir_en, bus.hist_wen, bus.mm_start}), 0);
    end
    check("reset_hist_addr", int'(bus.hist_addr), 0);
    check("reset_in_addr", int'(bus.input_mem_addr), 0);
    check("reset_run_cycles", int'(run_cycles), 0);
    @(negedge clk) begin rst_n = 1; start = 0; end
    repeat (3) @(negedge clk);
    #1 check("reset_stays_idle", int'(busy), 0);
    $display("reset: outputs idle during and after reset");

    // Table-driven runs.
    for (int v = 0; v < 4; v++)
      run_one($sformatf("vec%0d", v), vecs[v].d0, vecs[v].d1, vecs[v].d2, vecs[v].len,
              vecs[v].dly, vecs[v].restart_at, vecs[v].exp_pre_mm, vecs[v].exp_busy);

    // start and abort together in IDLE: abort wins.
    @(negedge clk) begin start = 1; abort = 1; end
    @(negedge clk) begin start = 0; abort = 0; end
    #1 check("start_abort_idle", int'(busy), 0);
    $display("start+abort in idle: busy=%0d", busy);

    // Abort on the second STORE (cycle 6).
    begin
      int na, a0, mmc;
      na = 0; a0 = -1; mmc = 0;
      ram[0] = 10; ram[1] = 20; ram[2] = 30; mm_len = 5; mm_delay = 1;
      @(negedge clk) start = 1;
      @(negedge clk) start = 0;
      for (int cyc = 1; cyc <= 12; cyc++) begin
        abort = (cyc == 6);
        #1;
        if (bus.hist_wen) begin
          if (na == 0) a0 = int'(bus.hist_addr);
          na++;
        end
        if (bus.mm_start) mmc++;
        if (cyc == 7) check("abort_busy_next", int'(busy), 0);
        @(negedge clk);
      end
      abort = 0;
      check("abort_nwrites", na, 1);
      check("abort_addr0", a0, 0);
      check("abort_done", int'(done), 0);
      check("abort_no_mm", mmc, 0);
      check("abort_hist_addr_reset", int'(bus.hist_addr), 0);
      $display("abort: %0d writes, mm_start count %0d, done=%0d", na, mmc, done);
    end

    // Reset mid-run behaves like power-on reset.
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    repeat (9) @(negedge clk);
    rst_n = 0;
    @(negedge clk) rst_n = 1;
    #1;
    check("midreset_busy", int'(busy), 0);
    check("midreset_done", int'(done), 0);
    check("midreset_addr", int'(bus.hist_addr), 0);
    $display("mid-run reset: busy=%0d done=%0d", busy, done);

    // Randomized runs against the reference rules.
    for (int r = 0; r < 6; r++) begin
      int len, dly, rs;
      len = int'($urandom_range(8, 1));
      dly = int'($urandom_range(4, 1));
      rs  = ($urandom_range(1, 0) == 1) ? int'($urandom_range(20, 2)) : 0;
      run_one($sformatf("rnd%0d", r), $urandom, $urandom, $urandom, len, dly, rs,
              3 * NS * VN, 3 * NS * VN + dly + len + 2);
    end

    // Full address space: 16 writes, address reaches 15 with no wrap.
    wcnt = 0; max_addr = -1; ended = 0; mm_cnt = 0;
    @(negedge clk) start2 = 1;
    @(negedge clk) start2 = 0;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      #1;
      if (!busy2) begin
        ended = 1;
        break;
      end
      if (bus2.hist_wen) begin
        exp_d = ram2[wcnt / VN2] + 32'd1;
        check($sformatf("max_addr%0d", wcnt), int'(bus2.hist_addr), wcnt);
        check($sformatf("max_data%0d", wcnt), int'(bus2.hist_din), int'(exp_d));
        if (int'(bus2.hist_addr) > max_addr) max_addr = int'(bus2.hist_addr);
        wcnt++;
      end
      if (bus2.mm_start) mm_cnt++;
      @(negedge clk);
    end
    check("max_ended", ended, 1);
    check("max_nwrites", wcnt, 16);
    check("max_top_addr", max_addr, 15);
    check("max_mm_pulses", mm_cnt, 1);
    check("max_done", int'(done2), 1);
    $display("max size: %0d writes, highest address %0d", wcnt, max_addr);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
